fft_radix2_proc: RTL and testbench
==================================

Name: fft_radix2_proc

Overview:
- Parametrised in-place radix-2 DIT FFT/IFFT processor; next generation of the fixed 8-point FFT processor.
- Point count, data width and direction are configurable.
- Loads N complex samples over a valid/ready stream and computes with one time-shared butterfly over an internal register file.
- Drains results in natural order over a valid/ready stream; sits between the sample source and the spectrum consumer in the DSP datapath.

Parameters:
- LOG2N, 3, log2 of point count N (legal 2..6; N = 8 by default).
- W, 16, signed width of the real and imaginary parts of each sample.
- TW, 16, signed twiddle width; format Q1.(TW-2), so +1.0 = 2^(TW-2).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begins a transform; ignored unless in IDLE
- inv  in  1  sampled on the accepted start; 1 selects IFFT (conjugate twiddles)
- in_valid  in  1  input sample valid
- in_ready  out  1  high in LOAD only
- in_re, in_im  in  W each  input sample
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_re, out_im  out  W each  result sample
- out_idx  out  LOG2N  bin index of the current result
- busy  out  1  high whenever not IDLE
- done  out  1  one-cycle pulse after the last result is accepted

Behaviour:
- Reset and interface:
  - One clock; reset is synchronous and active-high (ports clk, rst).
  - On rst: state=IDLE; in_ready, out_valid, busy and done are 0; out_re, out_im and out_idx are 0; counters are 0.
  - Register-file contents are don't-care after reset.
  - rst asserted mid-operation aborts immediately to IDLE. No partial output.
- States: IDLE -> LOAD -> COMPUTE -> UNLOAD -> IDLE.
- IDLE:
  - start=1 latches inv, clears the sample counter and enters LOAD next cycle.
- LOAD:
  - in_ready=1. Each cycle with in_valid&in_ready writes the sample to address bitrev(cnt) and increments cnt.
  - After the N-th accept, enter COMPUTE. No timeout.
- COMPUTE:
  - Performs one butterfly per cycle.
  - Stage s = 0..LOG2N-1, butterfly k = 0..N/2-1.
  - span = 2^s; group g = k >> s; j = k & (span-1).
  - Addresses: a = g*2*span + j and b = a + span. Twiddle index = j << (LOG2N-1-s).
  - Reads are combinational and the write-back of both results is registered in the same cycle.
  - COMPUTE lasts exactly LOG2N*N/2 cycles (12 for N=8), then UNLOAD.
- Arithmetic:
  - t = b*w, complex multiply, with products of W+TW bits.
  - Round: add 2^(TW-3), then arithmetic shift right by TW-2.
  - a' = a + t and b' = a - t, each W+1 bits, then reduced to W bits (see Optional Feature).
  - inv=1 uses conj(w). No 1/N in IFFT beyond the per-stage scaling.
- UNLOAD:
  - out_valid=1. out_idx = unload counter; data is read at natural address out_idx.
  - Advance on out_valid&out_ready. out_re, out_im and out_idx stay stable while stalled.
  - After the N-th accept: out_valid=0, done=1 for one cycle, then IDLE.
- start during LOAD, COMPUTE or UNLOAD is ignored. start and rst asserted together: rst wins.

Optional Feature:
- FFT_STAGE_SCALE_EN defined:
  - Each stage's W+1 result is arithmetically shifted right by 1, so total scaling is 1/N and overflow is impossible.
- Not defined:
  - No scaling; the W+1 result saturates to [-2^(W-1), 2^(W-1)-1].
  - Adds a sticky output ovf (1 bit), set on any saturation and cleared on accepted start or rst.

Decomposition:
- Package fft_pkg holds:
  - state encoding localparams (IDLE/LOAD/COMPUTE/UNLOAD);
  - Q-format constants (ONE = 2^(TW-2), ROUND = 2^(TW-3));
  - the bitrev function.
- Sub-module fft_twiddle_rom: combinational ROM indexed 0..N/2-1.
  - Returns cos and -sin of 2*pi*k/N, rounded to Q1.(TW-2).
  - Generated at elaboration from a 64-entry quarter-wave-symmetric table covering LOG2N up to 6.

Test Plan:
- N=8, scale on, forward; impulse x[0]=1000+0j, rest 0 -> all 8 outputs 125+0j (±1); done pulses once; total latency 8 (load) + 12 (compute) + 8 (unload) cycles with out_ready=1.
- N=8, scale on, forward; DC x[n]=800+0j for all n -> X[0]=800, X[1..7]=0 (±1 LSB).
- N=8, scale on, forward; x[n]=8192*cos(2*pi*n/8) -> X[1]=X[7]=4096 (±2), others 0 (±2); verifies bit-reversed load and twiddle indexing.
- Round trip:
  - Forward FFT of x=[100,200,...,800], then feed the result with inv=1.
  - Expected IFFT output is x/8 (±2), i.e. 12.5, 25 ... in integer-rounded form.
- Handshake:
  - Toggle in_valid and out_ready randomly.
  - Expect identical results to the ungated run and outputs held stable during stalls.
  - start pulsed during COMPUTE has no effect.
- rst asserted in the 5th COMPUTE cycle -> next cycle busy=0, out_valid=0, state=IDLE; a fresh impulse run then gives the correct result.
- Scale off, N=8; x[n]=32767 for all n -> ovf=1 and X[0] saturates to 32767.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types and helpers for the radix-2 FFT processor: FSM states,
// Q1.(TW-2) format constants and the bit-reversal used for the load address.
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    COMPUTE = 2'd2,
    UNLOAD  = 2'd3
  } state_t;

  localparam int MAX_LOG2N = 6;

  function automatic int q_one(input int tw);
    return 1 << (tw - 2);
  endfunction

  function automatic int q_round(input int tw);
    return 1 << (tw - 3);
  endfunction

  // Reverses the low 'bits' bits of v; upper bits come back as zero.
  function automatic logic [MAX_LOG2N-1:0] bitrev(input logic [MAX_LOG2N-1:0] v,
                                                  input int bits);
    logic [MAX_LOG2N-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_LOG2N; i++)
      if (i < bits) r[i] = v[bits-1-i];
    return r;
  endfunction

endpackage

// File: rtl/fft_radix2_proc_twiddle.sv
// Combinational twiddle ROM: w[k] = cos(2*pi*k/N) - j*sin(2*pi*k/N) in Q1.(TW-2),
// built at elaboration from a quarter wave of a 64-point cosine table (Q1.14).
module fft_twiddle_rom
  import fft_pkg::*;
#(
  parameter int LOG2N = 3,
  parameter int TW    = 16
) (
  input  logic [LOG2N-2:0]       idx,
  output logic signed [TW-1:0]   w_re,
  output logic signed [TW-1:0]   w_im
);

  localparam int N  = 1 << LOG2N;
  localparam int UP = (TW >= 16) ? TW - 16 : 0;
  localparam int DN = (TW >= 16) ? 0 : 16 - TW;

  // cos(2*pi*m/64) in Q1.14 for the first quarter wave, m = 0..16.
  function automatic int qw(input int m);
    case (m)
      0: return 16384;   1: return 16305;   2: return 16069;   3: return 15679;
      4: return 15137;   5: return 14449;   6: return 13623;   7: return 12665;
      8: return 11585;   9: return 10394;  10: return 9102;   11: return 7723;
      12: return 6270;   13: return 4756;  14: return 3196;   15: return 1606;
      default: return 0;
    endcase
  endfunction

  function automatic logic signed [TW-1:0] rescale(input int v);
    return TW'(((v <<< UP) + ((1 <<< DN) >>> 1)) >>> DN);
  endfunction

  logic signed [TW-1:0] rom_re [N/2];
  logic signed [TW-1:0] rom_im [N/2];

  for (genvar k = 0; k < N/2; k++) begin : g_rom
    localparam int M  = k << (MAX_LOG2N - LOG2N);
    localparam int CV = (M <= 16) ? qw(M) : -qw(32 - M);
    localparam int SV = (M <= 16) ? -qw(16 - M) : -qw(M - 16);
    assign rom_re[k] = rescale(CV);
    assign rom_im[k] = rescale(SV);
  end

  assign w_re = rom_re[idx];
  assign w_im = rom_im[idx];

endmodule

// File: rtl/fft_radix2_proc.sv
// In-place radix-2 DIT FFT/IFFT with one time-shared butterfly over a register file.
// FFT_STAGE_SCALE_EN: halve every stage (1/N overall); otherwise saturate and expose sticky ovf.
module fft_radix2_proc
  import fft_pkg::*;
#(
  parameter int LOG2N = 3,
  parameter int W     = 16,
  parameter int TW    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 inv,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [W-1:0]  in_re,
  input  logic signed [W-1:0]  in_im,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [W-1:0]  out_re,
  output logic signed [W-1:0]  out_im,
  output logic [LOG2N-1:0]     out_idx,
  output logic                 busy,
  output logic                 done
`ifndef FFT_STAGE_SCALE_EN
  ,
  output logic                 ovf
`endif
);

  localparam int N  = 1 << LOG2N;
  localparam int PW = W + TW + 1;
  localparam int SW = W + 3;

  state_t state, state_nx;
  logic [LOG2N-1:0] cnt;
  logic [2:0]       stg;
  logic             inv_q;

  logic signed [W-1:0] mem_re [N];
  logic signed [W-1:0] mem_im [N];

  logic in_acc, out_acc, last_cnt, k_last, last_bfly;
  logic [LOG2N-1:0] k_ext, span, mask, a_addr, b_addr, ld_addr;
  logic [LOG2N-2:0] tw_idx;

  assign in_acc    = (state == LOAD) && in_valid;
  assign out_acc   = (state == UNLOAD) && out_ready;
  assign last_cnt  = &cnt;
  assign k_last    = &cnt[LOG2N-2:0];
  assign last_bfly = k_last && (stg == 3'(LOG2N - 1));
  assign ld_addr   = LOG2N'(bitrev(MAX_LOG2N'(cnt), LOG2N));

  // NOTE: every always_comb target gets a default first, so no latch can be inferred.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = LOAD;
      LOAD:    if (in_acc && last_cnt) state_nx = COMPUTE;
      COMPUTE: if (last_bfly) state_nx = UNLOAD;
      UNLOAD:  if (out_acc && last_cnt) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign in_ready  = (state == LOAD);
  assign out_valid = (state == UNLOAD);
  assign busy      = (state != IDLE);
  assign out_idx   = out_valid ? cnt : '0;
  assign out_re    = out_valid ? mem_re[cnt] : '0;
  assign out_im    = out_valid ? mem_im[cnt] : '0;

  // Butterfly k of stage s pairs a = g*2*span + j with b = a + span.
  always_comb begin
    k_ext  = {1'b0, cnt[LOG2N-2:0]};
    span   = LOG2N'(1 << stg);
    mask   = span - LOG2N'(1);
    a_addr = ((k_ext >> stg) << (stg + 3'd1)) | (k_ext & mask);
    b_addr = a_addr | span;
    tw_idx = (LOG2N-1)'((k_ext & mask) << (3'(LOG2N - 1) - stg));
  end

  logic signed [TW-1:0] wr, wi_rom, wi;
  logic signed [W-1:0]  ar, ai, br, bi;
  logic signed [PW-1:0] tr_full, ti_full;
  logic signed [SW-1:0] tr, ti, sum_re, sum_im, dif_re, dif_im;
  logic signed [W-1:0]  a_re_nx, a_im_nx, b_re_nx, b_im_nx;

  fft_twiddle_rom #(.LOG2N(LOG2N), .TW(TW)) u_rom (
    .idx  (tw_idx),
    .w_re (wr),
    .w_im (wi_rom)
  );

`ifdef FFT_STAGE_SCALE_EN
  function automatic logic signed [W-1:0] reduce(input logic signed [SW-1:0] v);
    return W'(v >>> 1);
  endfunction
`else
  localparam logic signed [SW-1:0] MAX_S = {4'b0000, {(W-1){1'b1}}};
  localparam logic signed [SW-1:0] MIN_S = {4'b1111, {(W-1){1'b0}}};

  function automatic logic oor(input logic signed [SW-1:0] v);
    return (v > MAX_S) || (v < MIN_S);
  endfunction

  function automatic logic signed [W-1:0] reduce(input logic signed [SW-1:0] v);
    if (v > MAX_S) return W'(MAX_S);
    if (v < MIN_S) return W'(MIN_S);
    return W'(v);
  endfunction
`endif

  always_comb begin
    ar      = mem_re[a_addr];
    ai      = mem_im[a_addr];
    br      = mem_re[b_addr];
    bi      = mem_im[b_addr];
    wi      = inv_q ? -wi_rom : wi_rom;
    tr_full = PW'(br) * PW'(wr) - PW'(bi) * PW'(wi) + PW'(q_round(TW));
    ti_full = PW'(br) * PW'(wi) + PW'(bi) * PW'(wr) + PW'(q_round(TW));
    tr      = SW'(tr_full >>> (TW - 2));
    ti      = SW'(ti_full >>> (TW - 2));
    sum_re  = SW'(ar) + tr;
    sum_im  = SW'(ai) + ti;
    dif_re  = SW'(ar) - tr;
    dif_im  = SW'(ai) - ti;
    a_re_nx = reduce(sum_re);
    a_im_nx = reduce(sum_im);
    b_re_nx = reduce(dif_re);
    b_im_nx = reduce(dif_im);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      stg   <= '0;
      inv_q <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: if (start) begin
          cnt   <= '0;
          stg   <= '0;
          inv_q <= inv;
        end
        LOAD: if (in_valid) cnt <= cnt + LOG2N'(1);
        COMPUTE: if (k_last) begin
          cnt <= '0;
          stg <= stg + 3'd1;
        end else begin
          cnt <= cnt + LOG2N'(1);
        end
        UNLOAD: if (out_ready) begin
          cnt <= cnt + LOG2N'(1);
          if (last_cnt) done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: the register file has no reset; its contents are don't-care until loaded.
  always_ff @(posedge clk) begin
    if (in_acc) begin
      mem_re[ld_addr] <= in_re;
      mem_im[ld_addr] <= in_im;
    end else if (state == COMPUTE) begin
      mem_re[a_addr] <= a_re_nx;
      mem_im[a_addr] <= a_im_nx;
      mem_re[b_addr] <= b_re_nx;
      mem_im[b_addr] <= b_im_nx;
    end
  end

`ifndef FFT_STAGE_SCALE_EN
  logic sat_any;
  assign sat_any = oor(sum_re) | oor(sum_im) | oor(dif_re) | oor(dif_im);

  always_ff @(posedge clk) begin
    if (rst)                              ovf <= 1'b0;
    else if (state == IDLE && start)      ovf <= 1'b0;
    else if (state == COMPUTE && sat_any) ovf <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_fft_radix2_proc.sv
// Self-checking bench for fft_radix2_proc (N=8): results are compared against a
// real-valued DFT of the driven samples, scaled and clamped as the build selects.
module tb_fft_radix2_proc;

  localparam int LOG2N = 3;
  localparam int W     = 16;
  localparam int TW    = 16;
  localparam int N     = 8;
  localparam real PI   = 3.14159265358979;
`ifdef FFT_STAGE_SCALE_EN
  localparam real SCALE = 8.0;
  localparam int  TOL   = 2;
  localparam int  RTTOL = 2;
  localparam int  AMP   = 8192;
`else
  localparam real SCALE = 1.0;
  localparam int  TOL   = 3;
  localparam int  RTTOL = 6;
  localparam int  AMP   = 4096;
`endif

  logic clk, rst, start, inv, in_valid, in_ready, out_valid, out_ready, busy, done;
  logic signed [W-1:0] in_re, in_im, out_re, out_im;
  logic [LOG2N-1:0] out_idx;
`ifndef FFT_STAGE_SCALE_EN
  logic ovf;
`endif

  fft_radix2_proc #(.LOG2N(LOG2N), .W(W), .TW(TW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .inv       (inv),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_im     (in_im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_idx   (out_idx),
    .busy      (busy),
    .done      (done)
`ifndef FFT_STAGE_SCALE_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int drv_re[N], drv_im[N], exp_re[N], exp_im[N], res_re[N], res_im[N];
  int busy_cycles, done_cnt;

  task automatic check(input string tag, input int got, input int exp, input int tol);
    checks++;
    if ((got > exp + tol) || (got < exp - tol)) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (+/-%0d)", tag, got, exp, tol);
    end
  endtask

  function automatic int to_int(input real v);
    real r;
    r = $floor(v + 0.5);
    if (r > 32767.0)  r = 32767.0;
    if (r < -32768.0) r = -32768.0;
    return $rtoi(r);
  endfunction

  // Direct DFT of drv_* (sign of the exponent chosen by inv), then build scaling.
  task automatic model(input bit inv_i);
    for (int k = 0; k < N; k++) begin
      real sr, si, ang;
      sr = 0.0;
      si = 0.0;
      for (int n = 0; n < N; n++) begin
        ang = 2.0 * PI * n * k / N;
        if (!inv_i) ang = -ang;
        sr += drv_re[n] * $cos(ang) - drv_im[n] * $sin(ang);
        si += drv_re[n] * $sin(ang) + drv_im[n] * $cos(ang);
      end
      exp_re[k] = to_int(sr / SCALE);
      exp_im[k] = to_int(si / SCALE);
    end
  endtask

  task automatic compare(input string tag, input int tol);
    for (int k = 0; k < N; k++) begin
      check($sformatf("%s_re[%0d]", tag, k), res_re[k], exp_re[k], tol);
      check($sformatf("%s_im[%0d]", tag, k), res_im[k], exp_im[k], tol);
    end
  endtask

  // One full transform; p_in/p_out are percent chances of in_valid/out_ready.
  task automatic transform(input bit inv_i, input int p_in, input int p_out, input bit spam);
    int li, ui;
    bit pv, pr;
    int p_re, p_im, p_idx;
    li = 0; ui = 0; pv = 0; pr = 0; p_re = 0; p_im = 0; p_idx = 0;
    busy_cycles = 0;
    done_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    inv   = inv_i;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      inv   = 1'b0;
      if (spam && busy && !in_ready && !out_valid) start = 1'($urandom_range(1));
      if (busy) busy_cycles++;
      if (done) done_cnt++;
      in_valid = 1'b0;
      if (in_ready && li < N && $urandom_range(99) < p_in) begin
        in_valid = 1'b1;
        in_re    = W'(drv_re[li]);
        in_im    = W'(drv_im[li]);
        li++;
      end
      if (out_valid) begin
        if (pv && !pr) begin
          check("stall_re", out_re, p_re, 0);
          check("stall_im", out_im, p_im, 0);
          check("stall_idx", out_idx, p_idx, 0);
        end
        out_ready = ($urandom_range(99) < p_out);
        pv = 1'b1; pr = out_ready; p_re = out_re; p_im = out_im; p_idx = out_idx;
        if (out_ready && ui < N) begin
          check("order", out_idx, ui, 0);
          res_re[ui] = out_re;
          res_im[ui] = out_im;
          ui++;
        end
      end else begin
        pv = 1'b0;
        out_ready = 1'($urandom_range(1));
      end
      if (done) begin
        check("done_no_valid", out_valid, 0, 0);
        break;
      end
    end
    in_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("done_once", done_cnt, 1, 0);
  endtask

  task automatic fill(input int re0, input int re_rest);
    for (int n = 0; n < N; n++) begin
      drv_re[n] = (n == 0) ? re0 : re_rest;
      drv_im[n] = 0;
    end
  endtask

  int x_rt[N];
  int ncomp, li;

  initial begin
    rst = 1'b1; start = 1'b0; inv = 1'b0; in_valid = 1'b0;
    in_re = '0; in_im = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0, 0);
    check("rst_out_valid", out_valid, 0, 0);
    check("rst_busy", busy, 0, 0);
    check("rst_done", done, 0, 0);
    check("rst_out_re", out_re, 0, 0);
    check("rst_out_im", out_im, 0, 0);
    check("rst_out_idx", out_idx, 0, 0);
`ifndef FFT_STAGE_SCALE_EN
    check("rst_ovf", ovf, 0, 0);
`endif
    rst = 1'b0;

    // Impulse, plus latency of load + compute + unload at full throughput.
    fill(1000, 0);
    model(1'b0);
    transform(1'b0, 100, 100, 1'b0);
    compare("impulse", 1);
    check("latency", busy_cycles, N + 12 + N, 0);

    fill(800, 800);
    model(1'b0);
    transform(1'b0, 100, 100, 1'b0);
    compare("dc", 1);

    for (int n = 0; n < N; n++) begin
      drv_re[n] = to_int(AMP * $cos(2.0 * PI * n / N));
      drv_im[n] = 0;
    end
    model(1'b0);
    transform(1'b0, 100, 100, 1'b0);
    compare("cos", 2);

    // Round trip: forward, then feed the spectrum back with inv=1.
    for (int n = 0; n < N; n++) begin
      x_rt[n]   = 100 * (n + 1);
      drv_re[n] = x_rt[n];
      drv_im[n] = 0;
    end
    transform(1'b0, 100, 100, 1'b0);
    for (int n = 0; n < N; n++) begin
      drv_re[n] = res_re[n];
      drv_im[n] = res_im[n];
      exp_re[n] = to_int(x_rt[n] * N / (SCALE * SCALE));
      exp_im[n] = 0;
    end
    transform(1'b1, 100, 100, 1'b0);
    compare("roundtrip", RTTOL);

    // Random data, ungated and then gated with start pulses during compute.
    for (int it = 0; it < 3; it++) begin
      bit inv_r;
      inv_r = 1'($urandom_range(1));
      for (int n = 0; n < N; n++) begin
        drv_re[n] = int'($urandom_range(4000)) - 2000;
        drv_im[n] = int'($urandom_range(4000)) - 2000;
      end
      model(inv_r);
      transform(inv_r, 100, 100, 1'b0);
      compare($sformatf("rand%0d", it), TOL);
      transform(inv_r, 50, 50, 1'b1);
      compare($sformatf("gated%0d", it), TOL);
    end

    // Synchronous reset in the 5th compute cycle aborts to idle.
    fill(1000, 0);
    li = 0;
    ncomp = 0;
    @(negedge clk);
    start = 1'b1;
    for (int c = 0; c < 200 && ncomp < 5; c++) begin
      @(negedge clk);
      start    = 1'b0;
      in_valid = 1'b0;
      if (in_ready && li < N) begin
        in_valid = 1'b1;
        in_re    = W'(drv_re[li]);
        in_im    = W'(drv_im[li]);
        li++;
      end
      if (busy && !in_ready && !out_valid) ncomp++;
    end
    check("reached_compute5", ncomp, 5, 0);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 0, 0);
    check("abort_out_valid", out_valid, 0, 0);
    check("abort_in_ready", in_ready, 0, 0);
    check("abort_done", done, 0, 0);
    rst = 1'b0;
    model(1'b0);
    transform(1'b0, 100, 100, 1'b0);
    compare("after_abort", 1);

    // Full-scale DC drives the DC bin to the positive limit.
    fill(32767, 32767);
    model(1'b0);
    transform(1'b0, 100, 100, 1'b0);
    compare("fullscale", TOL);
`ifndef FFT_STAGE_SCALE_EN
    check("ovf_set", ovf, 1, 0);
    check("sat_x0", res_re[0], 32767, 0);
    fill(500, 0);
    model(1'b0);
    transform(1'b0, 100, 100, 1'b0);
    compare("post_sat", 1);
    check("ovf_cleared", ovf, 0, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
